// File: rtl/lock_key_loader_if.sv
// Key-store to loader bundle: serial key stream in, committed key and status out.
// master = key store side, slave = lock_key_loader.
interface lock_key_loader_if #(
  parameter int KEY_BITS = 10
);
  logic                load_start;
  logic                zeroize;
  logic                key_sdi;
  logic                key_valid;
  logic                key_ready;
  logic [KEY_BITS-1:0] key_out;
  logic                key_loaded;
  logic                load_busy;
  logic                load_err;

  modport master (
    output load_start, zeroize, key_sdi, key_valid,
    input  key_ready, key_out, key_loaded, load_busy, load_err
  );

  modport slave (
    input  load_start, zeroize, key_sdi, key_valid,
    output key_ready, key_out, key_loaded, load_busy, load_err
  );
endinterface

// File: rtl/lock_key_loader.sv
// Serial key loader: shifts key bits LSB first into a shadow register and commits atomically to key_out.
// Latency: key_out updates 2 edges after the final bit accept (optional parity via KEY_PARITY_CHECK_EN).
// Backpressure: key_ready is high only in SHIFT; key_valid is ignored elsewhere, idle gaps bounded by TIMEOUT.
module lock_key_loader #(
  parameter int KEY_BITS = 10,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lock_key_loader_if.slave kif
);

`ifdef KEY_PARITY_CHECK_EN
  localparam int FRAME_BITS = KEY_BITS + 1;
`else
  localparam int FRAME_BITS = KEY_BITS;
`endif
  localparam int              BC_W     = $clog2(FRAME_BITS + 1);
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_COMMIT,
    S_ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [KEY_BITS-1:0] shadow;
  logic [KEY_BITS-1:0] key_q;
  logic [BC_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]    to_cnt;
  logic                key_loaded_q;
  logic                load_err_q;
  logic                accept;
  logic                do_restart;
  logic                do_commit;
  logic                do_error;
`ifdef KEY_PARITY_CHECK_EN
  logic                par_bit;
`endif

  assign accept         = (state == S_SHIFT) && kif.key_valid;
  assign kif.key_ready  = (state == S_SHIFT);
  assign kif.load_busy  = (state == S_SHIFT) || (state == S_CHECK) || (state == S_COMMIT);
  assign kif.key_out    = key_q;
  assign kif.key_loaded = key_loaded_q;
  assign kif.load_err   = load_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // zeroize outranks load_start, which outranks any in-flight frame activity
  always_comb begin
    state_nxt  = state;
    do_restart = 1'b0;
    do_commit  = 1'b0;
    do_error   = 1'b0;
    if (kif.zeroize) begin
      state_nxt = S_IDLE;
    end else if (kif.load_start) begin
      state_nxt  = S_SHIFT;
      do_restart = 1'b1;
    end else begin
      case (state)
        S_SHIFT: begin
          if (accept && (bit_cnt == LAST_IDX)) begin
            state_nxt = S_CHECK;
          end else if (!accept && (to_cnt == TO_LAST)) begin
            state_nxt = S_ERROR;
            do_error  = 1'b1;
          end
        end
        S_CHECK: begin
`ifdef KEY_PARITY_CHECK_EN
          if ((^shadow) == par_bit) begin
            state_nxt = S_COMMIT;
          end else begin
            state_nxt = S_ERROR;
            do_error  = 1'b1;
          end
`else
          state_nxt = S_COMMIT;
`endif
        end
        S_COMMIT: begin
          state_nxt = S_IDLE;
          do_commit = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= '0;
      key_q        <= '0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      key_loaded_q <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef KEY_PARITY_CHECK_EN
      par_bit      <= 1'b0;
`endif
    end else if (kif.zeroize) begin
      shadow       <= '0;
      key_q        <= '0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      key_loaded_q <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef KEY_PARITY_CHECK_EN
      par_bit      <= 1'b0;
`endif
    end else if (do_restart) begin
      // a committed key stays on key_out while the new frame assembles
      shadow     <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      load_err_q <= 1'b0;
`ifdef KEY_PARITY_CHECK_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      if (do_error) begin
        key_q        <= '0;
        key_loaded_q <= 1'b0;
        load_err_q   <= 1'b1;
      end
      if (do_commit) begin
        key_q        <= shadow;
        key_loaded_q <= 1'b1;
      end
      if (state == S_SHIFT) begin
        if (accept) begin
          to_cnt  <= '0;
          bit_cnt <= bit_cnt + 1'b1;
`ifdef KEY_PARITY_CHECK_EN
          if (bit_cnt == LAST_IDX) begin
            par_bit <= kif.key_sdi;
          end else begin
            shadow <= shadow | (KEY_BITS'(kif.key_sdi) << bit_cnt);
          end
`else
          shadow  <= shadow | (KEY_BITS'(kif.key_sdi) << bit_cnt);
`endif
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// Scoreboard bench for lock_key_loader: expected frame outcomes are queued at stimulus time
// and checked by a monitor each time load_busy falls.
module tb_lock_key_loader;
  localparam int KB = 10;
`ifdef KEY_PARITY_CHECK_EN
  localparam int FL = KB + 1;
`else
  localparam int FL = KB;
`endif

  typedef struct packed {
    logic [KB-1:0] key;
    logic          loaded;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   rdy_cycles;
  logic prev_busy;
  exp_t sb[$];

  lock_key_loader_if #(.KEY_BITS(KB)) kif();

  lock_key_loader #(.KEY_BITS(KB), .TIMEOUT(255), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog sim time expired without finishing");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (kif.key_ready) rdy_cycles++;
      if (prev_busy && !kif.load_busy) begin
        a = '{key: kif.key_out, loaded: kif.key_loaded, err: kif.load_err};
        if (sb.size() == 0) begin
          chk("sb_unexpected_frame_end", 32'(a), 32'h8000_0000);
        end else begin
          e = sb.pop_front();
          chk("sb_frame_end", 32'(a), 32'(e));
        end
      end
      prev_busy = kif.load_busy;
    end
  endtask

  task automatic expect_end(input logic [KB-1:0] k, input logic ld, input logic er);
    sb.push_back('{key: k, loaded: ld, err: er});
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    kif.load_start = 1'b1;
    @(posedge clk); #1;
    kif.load_start = 1'b0;
  endtask

  task automatic push_bit(input logic b);
    bit done;
    done = 1'b0;
    kif.key_valid = 1'b1;
    kif.key_sdi   = b;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (kif.key_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    kif.key_valid = 1'b0;
    chk("accept_within_bound", 32'(done), 32'd1);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      push_bit(bits[i]);
      if (i < n - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [KB-1:0] k, input logic flip);
    logic [15:0] f;
    f = 16'(k);
`ifdef KEY_PARITY_CHECK_EN
    f[KB] = (^k) ^ flip;
`else
    f[KB] = flip;
`endif
    return f;
  endfunction

  // Sends a full frame and checks the 2-edge commit latency (or the error path).
  task automatic send_frame(input logic [KB-1:0] k, input int gap, input logic flip, input logic ok);
    send_bits(frame_bits(k, flip), FL, gap);
    chk("busy_after_last_accept", 32'(kif.load_busy), 32'd1);
    @(posedge clk); #1;
    if (ok) begin
      chk("busy_in_commit", 32'(kif.load_busy), 32'd1);
      @(posedge clk); #1;
      chk("key_out_2_edges", 32'(kif.key_out), 32'(k));
      chk("key_loaded_after_commit", 32'(kif.key_loaded), 32'd1);
      chk("busy_low_after_commit", 32'(kif.load_busy), 32'd0);
    end else begin
      chk("parity_err_flag", 32'(kif.load_err), 32'd1);
      chk("parity_err_key_zero", 32'(kif.key_out), 32'd0);
    end
  endtask

  initial begin
    int r0;
    checks = 0;
    errors = 0;
    rdy_cycles = 0;
    prev_busy = 1'b0;
    rst_n = 1'b0;
    kif.load_start = 1'b0;
    kif.zeroize    = 1'b0;
    kif.key_sdi    = 1'b0;
    kif.key_valid  = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_key_out", 32'(kif.key_out), 32'd0);
    chk("rst_key_loaded", 32'(kif.key_loaded), 32'd0);
    chk("rst_load_busy", 32'(kif.load_busy), 32'd0);
    chk("rst_load_err", 32'(kif.load_err), 32'd0);
    chk("rst_key_ready", 32'(kif.key_ready), 32'd0);
    #2 rst_n = 1'b1;

    // streaming frame, key_valid held high
    r0 = rdy_cycles;
    expect_end(10'h2CE, 1'b1, 1'b0);
    start_frame();
    send_frame(10'h2CE, 0, 1'b0, 1'b1);
    chk("ready_cycles_stream", 32'(rdy_cycles - r0), 32'(FL));

    // key_valid toggling: one idle cycle between accepts
    r0 = rdy_cycles;
    expect_end(10'h2CE, 1'b1, 1'b0);
    start_frame();
    send_frame(10'h2CE, 1, 1'b0, 1'b1);
    chk("ready_cycles_toggle", 32'(rdy_cycles - r0), 32'(2 * FL - 1));
    chk("toggle_no_err", 32'(kif.load_err), 32'd0);

    // timeout after 4 bits
    expect_end('0, 1'b0, 1'b1);
    start_frame();
    send_bits(16'h000E, 4, 0);
    repeat (250) begin @(posedge clk); #1; end
    chk("stall_250_no_err", 32'(kif.load_err), 32'd0);
    chk("stall_250_key_kept", 32'(kif.key_out), 32'h2CE);
    repeat (10) begin @(posedge clk); #1; end
    chk("timeout_err", 32'(kif.load_err), 32'd1);
    chk("timeout_key_zero", 32'(kif.key_out), 32'd0);
    chk("timeout_loaded_zero", 32'(kif.key_loaded), 32'd0);
    chk("timeout_ready_zero", 32'(kif.key_ready), 32'd0);
    expect_end(10'h155, 1'b1, 1'b0);
    start_frame();
    chk("restart_clears_err", 32'(kif.load_err), 32'd0);
    send_frame(10'h155, 0, 1'b0, 1'b1);

    // zeroize coincident with the 6th accept
    expect_end('0, 1'b0, 1'b0);
    start_frame();
    send_bits(16'h0155, 5, 0);
    kif.zeroize = 1'b1;
    push_bit(1'b1);
    kif.zeroize = 1'b0;
    chk("zeroize_key_out", 32'(kif.key_out), 32'd0);
    chk("zeroize_loaded", 32'(kif.key_loaded), 32'd0);
    chk("zeroize_busy", 32'(kif.load_busy), 32'd0);
    chk("zeroize_err", 32'(kif.load_err), 32'd0);
    r0 = rdy_cycles;
    kif.key_valid = 1'b1;
    kif.key_sdi   = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    kif.key_valid = 1'b0;
    chk("post_zeroize_ready_cycles", 32'(rdy_cycles - r0), 32'd0);
    chk("post_zeroize_key_out", 32'(kif.key_out), 32'd0);

    // async reset mid-frame after a committed key
    expect_end(10'h155, 1'b1, 1'b0);
    start_frame();
    send_frame(10'h155, 0, 1'b0, 1'b1);
    expect_end('0, 1'b0, 1'b0);
    start_frame();
    send_bits(16'h03FF, 7, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_key_out", 32'(kif.key_out), 32'd0);
    chk("async_rst_busy", 32'(kif.load_busy), 32'd0);
    chk("async_rst_loaded", 32'(kif.key_loaded), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_end(10'h0AA, 1'b1, 1'b0);
    start_frame();
    send_frame(10'h0AA, 0, 1'b0, 1'b1);

    // key_valid in IDLE is ignored
    r0 = rdy_cycles;
    kif.key_valid = 1'b1;
    kif.key_sdi   = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    kif.key_valid = 1'b0;
    chk("idle_valid_ignored_ready", 32'(rdy_cycles - r0), 32'd0);
    chk("idle_valid_key_kept", 32'(kif.key_out), 32'h0AA);

    // restart mid-frame: old key held, stale shadow bits discarded
    expect_end(10'h2CE, 1'b1, 1'b0);
    start_frame();
    send_bits(16'h0007, 3, 0);
    start_frame();
    chk("restart_key_kept", 32'(kif.key_out), 32'h0AA);
    chk("restart_busy", 32'(kif.load_busy), 32'd1);
    send_frame(10'h2CE, 0, 1'b0, 1'b1);

`ifdef KEY_PARITY_CHECK_EN
    expect_end('0, 1'b0, 1'b1);
    start_frame();
    send_frame(10'h2CE, 0, 1'b1, 1'b0);
    chk("parity_loaded_zero", 32'(kif.key_loaded), 32'd0);
`endif

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
